pairing_job_ctrl: RTL and testbench



---
 rtl/pairing_job_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_pairing_job_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pairing_job_ctrl.sv
// pairing_job_ctrl: host-side job sequencer for the pairing core.
// Ports: cmd_* job command, in_* operand stream, out_* result stream,
//        core_* pairing core run/extin/extout, done pulse, err_tmo flag.
module pairing_job_ctrl #(
    parameter int DATA_W     = 1216,
    parameter int ADDR_W     = 10,
    parameter int CNT_W      = 8,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int TMO_W      = 24
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_func,
    input  logic [CNT_W-1:0]  cmd_n_in,
    input  logic [CNT_W-1:0]  cmd_n_out,
    input  logic [ADDR_W-1:0] cmd_in_base,
    input  logic [ADDR_W-1:0] cmd_out_base,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              core_run,
    output logic [3:0]        core_n_func,
    output logic              core_extin_en,
    output logic [ADDR_W-1:0] core_extin_addr,
    output logic [DATA_W-1:0] core_extin_data,
    output logic [ADDR_W-1:0] core_extout_addr,
    input  logic [DATA_W-1:0] core_extout_data,
    input  logic              core_busy,
    input  logic              core_endflag,
    output logic              done,
    output logic              err_tmo
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(FIFO_DEPTH + RD_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT, S_UNLOAD, S_DONE
    } state_t;

    state_t            state;
    logic [3:0]        func_q;
    logic [CNT_W-1:0]  n_in_q, n_out_q, k_q, issued_q, popped_q;
    logic [ADDR_W-1:0] in_base_q, out_base_q, rd_addr_q;
    logic [TMO_W-1:0]  tmo_q;
    logic              first_q, err_q;
    logic [RD_LAT-1:0] vld_q;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     fifo_cnt;

    logic              cmd_hs, in_hs, issue, push, pop;
    logic [OW-1:0]     occ;
    logic [ADDR_W-1:0] rd_addr_nxt;
    logic [TMO_W-1:0]  tmo_nxt;

    function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign cmd_ready = (state == S_IDLE);
    assign in_ready  = (state == S_LOAD);
    assign core_run  = (state == S_START);
    assign done      = (state == S_DONE);
    assign err_tmo   = err_q;
    assign core_n_func = func_q;

    assign cmd_hs = cmd_valid & cmd_ready;
    assign in_hs  = in_valid & in_ready;

    // Operand words go straight through to the core write port.
    assign core_extin_en   = in_hs;
    assign core_extin_addr = in_base_q + ADDR_W'(k_q);
    assign core_extin_data = in_data;

    // Occupancy counts reads still in the core pipeline, so a full
    // pipeline plus FIFO can never exceed FIFO_DEPTH entries.
    always_comb begin
        occ = OW'(fifo_cnt);
        for (int i = 0; i < RD_LAT; i++) begin
            occ = occ + OW'(vld_q[i]);
        end
    end

    assign issue = (state == S_UNLOAD) && (issued_q != n_out_q)
                   && (occ < OW'(FIFO_DEPTH));
    assign rd_addr_nxt = out_base_q + ADDR_W'(issued_q);
    assign core_extout_addr = issue ? rd_addr_nxt : rd_addr_q;

    assign push      = vld_q[RD_LAT-1];
    assign out_valid = (fifo_cnt != '0);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid & out_ready;
    assign tmo_nxt   = tmo_q + TMO_W'(1);

    always_ff @(posedge clk) begin
        if (rstn && push) begin
            mem[wr_ptr] <= core_extout_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= S_IDLE;
            func_q     <= '0;
            n_in_q     <= '0;
            n_out_q    <= '0;
            in_base_q  <= '0;
            out_base_q <= '0;
            rd_addr_q  <= '0;
            k_q        <= '0;
            issued_q   <= '0;
            popped_q   <= '0;
            tmo_q      <= '0;
            first_q    <= 1'b0;
            err_q      <= 1'b0;
            vld_q      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
        end else begin
            vld_q[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
            if (push) wr_ptr <= inc_ptr(wr_ptr);
            if (pop)  rd_ptr <= inc_ptr(rd_ptr);
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
            if (issue) begin
                rd_addr_q <= rd_addr_nxt;
                issued_q  <= issued_q + CNT_W'(1);
            end
            if (pop)   popped_q <= popped_q + CNT_W'(1);
            if (in_hs) k_q      <= k_q + CNT_W'(1);

            unique case (state)
                S_IDLE: begin
                    if (cmd_hs) begin
                        func_q     <= cmd_func;
                        n_in_q     <= cmd_n_in;
                        n_out_q    <= cmd_n_out;
                        in_base_q  <= cmd_in_base;
                        out_base_q <= cmd_out_base;
                        k_q        <= '0;
                        issued_q   <= '0;
                        popped_q   <= '0;
                        err_q      <= 1'b0;
                        state <= (cmd_n_in == '0) ? S_START : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_hs && k_q == n_in_q - CNT_W'(1)) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    tmo_q   <= '0;
                    first_q <= 1'b1;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    // Core busy rises one cycle after run, so the
                    // first cycle may still show the old end flag.
                    first_q <= 1'b0;
                    tmo_q   <= tmo_nxt;
                    if (!first_q && core_endflag && !core_busy) begin
                        state <= (n_out_q == '0) ? S_DONE : S_UNLOAD;
                    end else if (tmo_nxt == '1) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_UNLOAD: begin
                    if (pop && popped_q == n_out_q - CNT_W'(1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pairing_job_ctrl.sv
// tb_pairing_job_ctrl: directed bench for pairing_job_ctrl.
// Second instance with TMO_W=4 exercises the completion timeout.
`timescale 1ns/1ps
module tb_pairing_job_ctrl;
    localparam int DATA_W = 1216;
    localparam int ADDR_W = 10;
    localparam int CNT_W  = 8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic cmd_valid = 1'b0, t_cmd_valid = 1'b0;
    logic [3:0] cmd_func = '0;
    logic [CNT_W-1:0] cmd_n_in = '0, cmd_n_out = '0;
    logic [ADDR_W-1:0] cmd_in_base = '0, cmd_out_base = '0;
    logic in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic out_ready = 1'b1;

    logic cmd_ready, in_ready, out_valid, core_run, core_extin_en, done;
    logic err_tmo;
    logic [DATA_W-1:0] out_data, core_extin_data, core_extout_data;
    logic [3:0] core_n_func;
    logic [ADDR_W-1:0] core_extin_addr, core_extout_addr;
    logic core_busy, core_endflag;

    logic t_cmd_ready, t_in_ready, t_out_valid, t_core_run;
    logic t_core_extin_en, t_done, t_err_tmo;
    logic [DATA_W-1:0] t_out_data, t_core_extin_data;
    logic [3:0] t_core_n_func;
    logic [ADDR_W-1:0] t_core_extin_addr, t_core_extout_addr;
    logic t_busy, t_endflag;
    assign t_busy = 1'b1;
    assign t_endflag = 1'b0;

    int n_asr = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_run = 0;
    int last_pop = -1;
    int done_cyc = -1;
    logic [ADDR_W-1:0] wa_q[$];
    logic [DATA_W-1:0] wd_q[$];
    logic [DATA_W-1:0] od_q[$];

    always #5 clk = ~clk;

    pairing_job_ctrl dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_func(cmd_func), .cmd_n_in(cmd_n_in),
        .cmd_n_out(cmd_n_out), .cmd_in_base(cmd_in_base),
        .cmd_out_base(cmd_out_base),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data),
        .core_run(core_run), .core_n_func(core_n_func),
        .core_extin_en(core_extin_en),
        .core_extin_addr(core_extin_addr),
        .core_extin_data(core_extin_data),
        .core_extout_addr(core_extout_addr),
        .core_extout_data(core_extout_data),
        .core_busy(core_busy), .core_endflag(core_endflag),
        .done(done), .err_tmo(err_tmo)
    );

    pairing_job_ctrl #(.TMO_W(4)) dut_t (
        .clk(clk), .rstn(rstn),
        .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready),
        .cmd_func(cmd_func), .cmd_n_in(cmd_n_in),
        .cmd_n_out(cmd_n_out), .cmd_in_base(cmd_in_base),
        .cmd_out_base(cmd_out_base),
        .in_valid(in_valid), .in_ready(t_in_ready), .in_data(in_data),
        .out_valid(t_out_valid), .out_ready(out_ready),
        .out_data(t_out_data),
        .core_run(t_core_run), .core_n_func(t_core_n_func),
        .core_extin_en(t_core_extin_en),
        .core_extin_addr(t_core_extin_addr),
        .core_extin_data(t_core_extin_data),
        .core_extout_addr(t_core_extout_addr),
        .core_extout_data(core_extout_data),
        .core_busy(t_busy), .core_endflag(t_endflag),
        .done(t_done), .err_tmo(t_err_tmo)
    );

    function automatic logic [DATA_W-1:0] mkword(
        input logic [ADDR_W-1:0] a, input logic [7:0] s);
        logic [DATA_W-1:0] w;
        w = '0;
        w[ADDR_W-1:0] = a;
        w[DATA_W-1 -: ADDR_W] = ~a;
        w[600 +: 8] = s;
        return w;
    endfunction

    // Core model: 2-cycle read latency, end flag 20 cycles after run.
    logic [ADDR_W-1:0] a1, a2;
    logic [7:0] ccnt;
    always @(posedge clk) begin
        a1 <= core_extout_addr;
        a2 <= a1;
        if (!rstn) begin
            ccnt <= '0;
            core_endflag <= 1'b0;
        end else if (core_run) begin
            ccnt <= 8'd19;
            core_endflag <= 1'b0;
        end else if (ccnt != '0) begin
            ccnt <= ccnt - 8'd1;
            if (ccnt == 8'd1) core_endflag <= 1'b1;
        end
    end
    assign core_busy = (ccnt != '0);
    assign core_extout_data = mkword(a2, 8'h5A);

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rstn) begin
            if (core_extin_en) begin
                wa_q.push_back(core_extin_addr);
                wd_q.push_back(core_extin_data);
            end
            if (core_run) n_run++;
            if (out_valid && out_ready) begin
                od_q.push_back(out_data);
                last_pop = cyc;
            end
            if (done) done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asr++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [DATA_W-1:0] obs,
                        input logic [DATA_W-1:0] exp);
        n_asr++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wa_q.delete();
        wd_q.delete();
        od_q.delete();
        n_run = 0;
    endtask

    task automatic send_cmd(input int f, input int ni, input int no,
                            input int ib, input int ob, input bit t);
        step();
        cmd_func = 4'(f);
        cmd_n_in = CNT_W'(ni);
        cmd_n_out = CNT_W'(no);
        cmd_in_base = ADDR_W'(ib);
        cmd_out_base = ADDR_W'(ob);
        if (t) begin
            t_cmd_valid = 1'b1;
            chk("t_cmd_ready", 32'(t_cmd_ready), 1);
        end else begin
            cmd_valid = 1'b1;
            chk("cmd_ready", 32'(cmd_ready), 1);
        end
        step();
        cmd_valid = 1'b0;
        t_cmd_valid = 1'b0;
    endtask

    task automatic send_words(input int n, input int ib);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data = mkword(ADDR_W'(ib + i), 8'(i + 1));
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300; i++) begin
            if (done) break;
            step();
        end
        chk("done_seen", 32'(done), 1);
        step();
        chk("done_pulse", 32'(done), 0);
        chk("idle_ready", 32'(cmd_ready), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) step();
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_run", 32'(core_run), 0);
        chk("rst_extin_en", 32'(core_extin_en), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err_tmo", 32'(err_tmo), 0);
        chk("rst_func", 32'(core_n_func), 0);
        chk("rst_rd_addr", 32'(core_extout_addr), 0);
        rstn = 1'b1;

        // Nominal job
        clear_logs();
        out_ready = 1'b1;
        send_cmd(4, 3, 2, 'h010, 'h100, 1'b0);
        chk("nom_func", 32'(core_n_func), 4);
        chk("nom_in_ready", 32'(in_ready), 1);
        chk("nom_busy_cmd", 32'(cmd_ready), 0);
        send_words(3, 'h010);
        wait_done();
        chk("nom_nwr", wa_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("nom_wr_addr", 32'(wa_q[i]), 'h010 + i);
            chkw("nom_wr_data", wd_q[i], mkword(ADDR_W'('h010 + i), 8'(i + 1)));
        end
        chk("nom_runs", n_run, 1);
        chk("nom_nout", od_q.size(), 2);
        chkw("nom_out0", od_q[0], mkword(10'h100, 8'h5A));
        chkw("nom_out1", od_q[1], mkword(10'h101, 8'h5A));
        chk("nom_done_lat", done_cyc, last_pop + 1);
        chk("nom_err", 32'(err_tmo), 0);

        // Backpressure
        clear_logs();
        out_ready = 1'b0;
        send_cmd(2, 0, 8, 0, 'h080, 1'b0);
        for (int i = 0; i < 100; i++) begin
            if (out_valid) break;
            step();
        end
        chk("bp_valid", 32'(out_valid), 1);
        repeat (30) step();
        chk("bp_rd_stall", 32'(core_extout_addr), 'h083);
        chk("bp_still_valid", 32'(out_valid), 1);
        chk("bp_no_pop", od_q.size(), 0);
        out_ready = 1'b1;
        wait_done();
        chk("bp_nout", od_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chkw("bp_out", od_q[i], mkword(ADDR_W'('h080 + i), 8'h5A));
        end
        chk("bp_nwr", wa_q.size(), 0);

        // Zero counts
        clear_logs();
        send_cmd(1, 0, 0, 'h020, 'h300, 1'b0);
        chk("zero_start", 32'(core_run), 1);
        wait_done();
        chk("zero_nwr", wa_q.size(), 0);
        chk("zero_nout", od_q.size(), 0);
        chk("zero_runs", n_run, 1);
        chk("zero_rd_hold", 32'(core_extout_addr), 'h087);

        // Timeout on the TMO_W=4 instance
        send_cmd(7, 0, 3, 0, 'h010, 1'b1);
        chk("tmo_run", 32'(t_core_run), 1);
        chk("tmo_func", 32'(t_core_n_func), 7);
        repeat (15) step();
        chk("tmo_err_early", 32'(t_err_tmo), 0);
        chk("tmo_done_early", 32'(t_done), 0);
        step();
        chk("tmo_err", 32'(t_err_tmo), 1);
        chk("tmo_done", 32'(t_done), 1);
        step();
        chk("tmo_done_pulse", 32'(t_done), 0);
        chk("tmo_err_sticky", 32'(t_err_tmo), 1);
        chk("tmo_no_unload", 32'(t_out_valid), 0);
        chk("tmo_idle", 32'(t_cmd_ready), 1);
        chk("tmo_no_rd", 32'(t_core_extout_addr), 0);
        send_cmd(7, 0, 0, 0, 0, 1'b1);
        chk("tmo_err_clear", 32'(t_err_tmo), 0);
        chk("tmo_no_wr", 32'(t_core_extin_en), 0);
        chk("tmo_in_ready", 32'(t_in_ready), 0);

        // Address wrap
        clear_logs();
        send_cmd(3, 2, 1, 'h3FF, 'h3FE, 1'b0);
        send_words(2, 'h3FF);
        wait_done();
        chk("wrap_nwr", wa_q.size(), 2);
        chk("wrap_addr0", 32'(wa_q[0]), 'h3FF);
        chk("wrap_addr1", 32'(wa_q[1]), 'h000);
        chkw("wrap_out", od_q[0], mkword(10'h3FE, 8'h5A));

        // Reset during UNLOAD
        clear_logs();
        out_ready = 1'b0;
        send_cmd(5, 0, 4, 0, 'h040, 1'b0);
        for (int i = 0; i < 100; i++) begin
            if (out_valid) break;
            step();
        end
        chk("rmid_valid", 32'(out_valid), 1);
        step();
        rstn = 1'b0;
        step();
        chk("rmid_out_valid", 32'(out_valid), 0);
        chk("rmid_cmd_ready", 32'(cmd_ready), 1);
        chk("rmid_in_ready", 32'(in_ready), 0);
        rstn = 1'b1;
        clear_logs();
        out_ready = 1'b1;
        send_cmd(6, 0, 1, 0, 'h050, 1'b0);
        wait_done();
        chk("rmid_nout", od_q.size(), 1);
        chkw("rmid_out", od_q[0], mkword(10'h050, 8'h5A));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asr, n_fail);
        $finish;
    end
endmodule
